// File: rtl/wire_mac_engine_if.sv
// Host-side wire bundle for wire_mac_engine.
//   ctrl_wire : control wire-in (bit0 start, bit1 clear)
//   op_a/op_b : operand wire-ins (low DATA_W bits used)
//   acc_lo/acc_hi/status : accumulator and status wire-outs
// master drives the wire-ins and reads the wire-outs; slave is the engine.
interface wire_mac_engine_if;
   logic [31:0] ctrl_wire;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] acc_lo;
   logic [31:0] acc_hi;
   logic [31:0] status;

   modport master (
      output ctrl_wire, op_a, op_b,
      input  acc_lo, acc_hi, status
   );

   modport slave (
      input  ctrl_wire, op_a, op_b,
      output acc_lo, acc_hi, status
   );
endinterface

// File: rtl/wire_mac_engine.sv
// Iterative unsigned multiply-accumulate engine sitting between FrontPanel
// wire-ins and wire-outs, fully in the okClk domain.
//
// Ports:
//   okClk   : host interface clock, all logic on rising edge
//   reset_n : synchronous active-low reset
//   host    : wire_mac_engine_if.slave
//               ctrl_wire (bit0 start, bit1 clear), op_a, op_b in
//               acc_lo = acc[31:0], acc_hi = acc[ACC_W-1:32] zero-extended
//               status = {count[15:0], 12'h0, start_dropped, overflow, done, busy}
//
// Configuration:
//   WIRE_MAC_SATURATE_EN : when defined, an accumulate that carries out of the
//   top bit clamps acc to all ones; otherwise acc wraps. overflow is sticky in
//   both builds.
module wire_mac_engine #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ACC_W  = 64
) (
   input  logic                okClk,
   input  logic                reset_n,
   wire_mac_engine_if.slave    host
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned ITER_W = $clog2(DATA_W + 1);
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned OUT_W  = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ACC  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [1:0]          ctrl_q;
   logic [PROD_W-1:0]   mcand;
   logic [DATA_W-1:0]   mplier;
   logic [PROD_W-1:0]   prod;
   logic [ITER_W-1:0]   iter;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    count;
   logic                busy;
   logic                done;
   logic                overflow;
   logic                start_dropped;

   logic                start_evt_c;
   logic                clear_evt_c;
   logic                latch_c;
   logic                step_c;
   logic                accum_c;
   logic                drop_c;
   logic [SUM_W-1:0]    acc_sum_c;
   logic                carry_c;
   logic [ACC_W-1:0]    acc_new_c;
   logic [OUT_W-1:0]    acc_ext_c;
   logic                unused_c;

   // Rising-edge detect on the control wire so level-held bits fire once.
   assign start_evt_c = host.ctrl_wire[0] & ~ctrl_q[0];
   assign clear_evt_c = host.ctrl_wire[1] & ~ctrl_q[1];

   // Accumulate adder with one extra bit to catch the carry-out.
   assign acc_sum_c = {1'b0, acc} + SUM_W'(prod);
   assign carry_c   = acc_sum_c[ACC_W];

`ifdef WIRE_MAC_SATURATE_EN
   assign acc_new_c = carry_c ? {ACC_W{1'b1}} : acc_sum_c[ACC_W-1:0];
`else
   assign acc_new_c = acc_sum_c[ACC_W-1:0];
`endif

   // Control-wire history register.
   always_ff @(posedge okClk) begin
      if (!reset_n) begin
         ctrl_q <= 2'b00;
      end else begin
         ctrl_q <= host.ctrl_wire[1:0];
      end
   end

   // State register.
   always_ff @(posedge okClk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and datapath strobes; clear overrides everything else.
   always_comb begin
      state_nxt = state;
      latch_c   = 1'b0;
      step_c    = 1'b0;
      accum_c   = 1'b0;
      drop_c    = 1'b0;

      if (clear_evt_c) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_evt_c) begin
                  latch_c   = 1'b1;
                  state_nxt = RUN;
               end
            end
            RUN: begin
               step_c = 1'b1;
               drop_c = start_evt_c;
               // iter reaches DATA_W on this edge, so the product is complete
               if (iter == ITER_W'(DATA_W - 1)) begin
                  state_nxt = ACC;
               end
            end
            ACC: begin
               accum_c   = 1'b1;
               drop_c    = start_evt_c;
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Shift-add multiplier: mcand is kept pre-shifted by iter, so each step
   // adds it in when the current multiplier LSB is set.
   always_ff @(posedge okClk) begin
      if (!reset_n) begin
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         iter   <= '0;
      end else if (latch_c) begin
         mcand  <= PROD_W'(host.op_a[DATA_W-1:0]);
         mplier <= host.op_b[DATA_W-1:0];
         prod   <= '0;
         iter   <= '0;
      end else if (step_c) begin
         if (mplier[0]) begin
            prod <= prod + mcand;
         end
         mcand  <= {mcand[PROD_W-2:0], 1'b0};
         mplier <= {1'b0, mplier[DATA_W-1:1]};
         iter   <= iter + ITER_W'(1);
      end
   end

   // Accumulator, count and status flags.
   always_ff @(posedge okClk) begin
      if (!reset_n) begin
         acc           <= '0;
         count         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         start_dropped <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         if (clear_evt_c) begin
            acc           <= '0;
            count         <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            start_dropped <= 1'b0;
         end else begin
            if (latch_c) begin
               done <= 1'b0;
            end
            if (accum_c) begin
               acc      <= acc_new_c;
               count    <= count + CNT_W'(1);
               done     <= 1'b1;
               overflow <= overflow | carry_c;
            end
            if (drop_c) begin
               start_dropped <= 1'b1;
            end
         end
      end
   end

   // Wire-out mapping straight from the flops.
   assign acc_ext_c   = OUT_W'(acc);
   assign host.acc_lo = acc_ext_c[31:0];
   assign host.acc_hi = acc_ext_c[63:32];
   assign host.status = {count, 12'h000, start_dropped, overflow, done, busy};

   // Ignored control bits and operand bits above DATA_W.
   assign unused_c = ^{host.ctrl_wire[31:2], host.op_a, host.op_b};

endmodule

// File: tb/tb_wire_mac_engine.sv
module tb_wire_mac_engine;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ACC_W  = 64;

   typedef struct {
      logic [63:0] acc;
      logic [31:0] status;
   } exp_t;

   logic okClk;
   logic reset_n;
   wire_mac_engine_if bus();

   wire_mac_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .okClk   (okClk),
      .reset_n (reset_n),
      .host    (bus.slave)
   );

   initial begin
      okClk = 1'b0;
      forever #5 okClk = ~okClk;
   end

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   // Reference model state
   logic [63:0] m_acc;
   logic [15:0] m_cnt;
   logic        m_ovf;
   logic        m_drop;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_status(input logic busy_b, input logic done_b);
      return {m_cnt, 12'h000, m_drop, m_ovf, done_b, busy_b};
   endfunction

   task automatic model_clear();
      m_acc  = '0;
      m_cnt  = '0;
      m_ovf  = 1'b0;
      m_drop = 1'b0;
   endtask

   // One accepted start: product by plain arithmetic, then push the snapshot
   // expected once the engine reports done.
   task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic extra_start);
      logic [63:0] p;
      logic [64:0] s;
      exp_t e;
      p = 64'(a) * 64'(b);
      s = 65'(m_acc) + 65'(p);
      if (s[64]) m_ovf = 1'b1;
`ifdef WIRE_MAC_SATURATE_EN
      m_acc = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
      m_acc = s[63:0];
`endif
      m_cnt = m_cnt + 16'd1;
      if (extra_start) m_drop = 1'b1;
      e.acc    = m_acc;
      e.status = model_status(1'b0, 1'b1);
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge okClk);
      #1;
   endtask

   task automatic pulse_start();
      bus.ctrl_wire[0] = 1'b1;
      step(1);
      bus.ctrl_wire[0] = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.ctrl_wire[1] = 1'b1;
      step(1);
      bus.ctrl_wire[1] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.status[0] === 1'b1 && n < 200) begin
         step(1);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy still %b after %0d cycles", name, bus.status[0], n);
      end
      step(2);
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int extra_delay);
      bus.op_a = a;
      bus.op_b = b;
      model_op(a, b, extra_delay > 0);
      pulse_start();
      // Operands scrambled mid-run must not matter
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      if (extra_delay > 0) begin
         step(extra_delay);
         pulse_start();
      end
      wait_idle("op");
   endtask

   // Monitor: each busy->idle fall with done set is a completion to score.
   initial begin
      int   busy_len;
      logic prev_busy;
      exp_t e;
      busy_len  = 0;
      prev_busy = 1'b0;
      forever begin
         @(negedge okClk);
         if (reset_n !== 1'b1) begin
            busy_len  = 0;
            prev_busy = 1'b0;
         end else begin
            if (bus.status[0] === 1'b1) begin
               busy_len++;
            end else begin
               if (prev_busy && bus.status[1] === 1'b1) begin
                  if (sb_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL sb_unexpected: completion with acc %h status %h, nothing expected",
                              {bus.acc_hi, bus.acc_lo}, bus.status);
                  end else begin
                     e = sb_q.pop_front();
                     check("sb_acc", {bus.acc_hi, bus.acc_lo}, e.acc);
                     check("sb_status", 64'(bus.status), 64'(e.status));
                     check("sb_busy_len", 64'(busy_len), 64'(DATA_W + 1));
                  end
               end
               busy_len = 0;
            end
            prev_busy = bus.status[0];
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      logic seen_busy;
      reset_n       = 1'b0;
      bus.ctrl_wire = '0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      model_clear();
      step(3);
      reset_n = 1'b1;
      @(negedge okClk);
      check("reset_acc", {bus.acc_hi, bus.acc_lo}, 64'h0);
      check("reset_status", 64'(bus.status), 64'h0);
      step(1);

      // Basic multiply
      do_op(32'd3, 32'd5, 0);
      check("basic_acc", {bus.acc_hi, bus.acc_lo}, 64'd15);
      check("basic_status", 64'(bus.status), 64'h0001_0002);

      // Wrap / saturate accumulate from a cleared accumulator
      pulse_clear();
      model_clear();
      @(negedge okClk);
      check("clear_status", 64'(bus.status), 64'h0);
      step(1);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("wrap1_acc", {bus.acc_hi, bus.acc_lo}, 64'hFFFF_FFFE_0000_0001);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`ifdef WIRE_MAC_SATURATE_EN
      check("wrap2_acc", {bus.acc_hi, bus.acc_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
      check("wrap2_acc", {bus.acc_hi, bus.acc_lo}, 64'hFFFF_FFFC_0000_0002);
`endif
      check("wrap2_status", 64'(bus.status), 64'h0002_0006);

      // Start while busy
      pulse_clear();
      model_clear();
      step(1);
      do_op(32'd1234, 32'd5678, 10);
      check("drop_acc", {bus.acc_hi, bus.acc_lo}, 64'd1234 * 64'd5678);
      check("drop_status", 64'(bus.status), 64'h0001_000A);

      // Level-held start
      pulse_clear();
      model_clear();
      step(1);
      bus.op_a = 32'd100;
      bus.op_b = 32'd200;
      model_op(32'd100, 32'd200, 1'b0);
      bus.ctrl_wire[0] = 1'b1;
      step(100);
      bus.ctrl_wire[0] = 1'b0;
      wait_idle("level");
      check("level_count", 64'(bus.status[31:16]), 64'd1);
      check("level_acc", {bus.acc_hi, bus.acc_lo}, 64'd20000);

      // Clear mid-RUN
      bus.op_a = 32'd9;
      bus.op_b = 32'd9;
      pulse_start();
      step(5);
      pulse_clear();
      model_clear();
      @(negedge okClk);
      check("midclr_status", 64'(bus.status), 64'h0);
      check("midclr_acc", {bus.acc_hi, bus.acc_lo}, 64'h0);
      step(DATA_W + 5);
      check("midclr_later_acc", {bus.acc_hi, bus.acc_lo}, 64'h0);

      // Simultaneous start + clear in IDLE
      do_op(32'd2, 32'd3, 0);
      bus.ctrl_wire[1:0] = 2'b11;
      step(1);
      bus.ctrl_wire[1:0] = 2'b00;
      model_clear();
      seen_busy = 1'b0;
      repeat (DATA_W + 4) begin
         @(negedge okClk);
         seen_busy = seen_busy | bus.status[0];
      end
      check("simul_busy", 64'(seen_busy), 64'h0);
      check("simul_status", 64'(bus.status), 64'h0);
      step(1);

      // Reset mid-operation
      do_op(32'd11, 32'd13, 0);
      bus.op_a = 32'd50;
      bus.op_b = 32'd60;
      pulse_start();
      step(8);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      model_clear();
      @(negedge okClk);
      check("rstmid_acc", {bus.acc_hi, bus.acc_lo}, 64'h0);
      check("rstmid_status", 64'(bus.status), 64'h0);
      step(1);
      do_op(32'd7, 32'd6, 0);
      check("rstmid_acc42", {bus.acc_hi, bus.acc_lo}, 64'd42);
      check("rstmid_status42", 64'(bus.status), 64'h0001_0002);

      // Randomized operations against the model
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         int          extra;
         if ($urandom_range(0, 7) == 0) begin
            pulse_clear();
            model_clear();
            step(1);
         end
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
         do_op(a, b, extra);
      end

      step(5);
      check("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
